// File: rtl/alu_uart_interface.sv
// Sequencer between UART RX/TX and a combinational ALU: collects A, B, opcode,
// captures the result and hands it to the transmitter. Optional macro: INTERFACE_TIMEOUT_EN.
module alu_uart_interface #(
  parameter int LENGTH         = 8,
  parameter int OP_WIDTH       = 6,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rx_done_tick,
  input  logic [LENGTH-1:0]   rx_data,
  input  logic [LENGTH-1:0]   alu_result,
  input  logic                tx_done_tick,
  output logic [LENGTH-1:0]   bus_a,
  output logic [LENGTH-1:0]   bus_b,
  output logic [OP_WIDTH-1:0] op,
  output logic                tx_start,
  output logic [LENGTH-1:0]   tx_data,
  output logic                busy
);

  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    COMPUTE = 3'd3,
    SEND    = 3'd4,
    WAIT_TX = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [LENGTH-1:0]   bus_a_q, bus_a_d;
  logic [LENGTH-1:0]   bus_b_q, bus_b_d;
  logic [OP_WIDTH-1:0] op_q, op_d;
  logic [LENGTH-1:0]   tx_data_q, tx_data_d;
  logic                tx_start_q, tx_start_d;
  logic                busy_q, busy_d;

`ifdef INTERFACE_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout;

  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Counts idle cycles between bytes; anything else (including WAIT_A) clears it.
  always_comb begin
    cnt_d = '0;
    if ((state_q == WAIT_B || state_q == WAIT_OP) && !rx_done_tick && !timeout)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= WAIT_A;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_A:  if (rx_done_tick) state_d = WAIT_B;
      WAIT_B: begin
        if (rx_done_tick) state_d = WAIT_OP;
`ifdef INTERFACE_TIMEOUT_EN
        else if (timeout) state_d = WAIT_A;
`endif
      end
      WAIT_OP: begin
        if (rx_done_tick) state_d = COMPUTE;
`ifdef INTERFACE_TIMEOUT_EN
        else if (timeout) state_d = WAIT_A;
`endif
      end
      COMPUTE: state_d = SEND;
      SEND:    state_d = WAIT_TX;
      WAIT_TX: if (tx_done_tick) state_d = WAIT_A;
      default: state_d = WAIT_A;
    endcase
  end

  // Output/datapath logic; status flags are registered from the next state so
  // they line up with the state they describe.
  always_comb begin
    bus_a_d    = bus_a_q;
    bus_b_d    = bus_b_q;
    op_d       = op_q;
    tx_data_d  = tx_data_q;
    tx_start_d = (state_d == SEND);
    busy_d     = (state_d == COMPUTE) || (state_d == SEND) || (state_d == WAIT_TX);
    case (state_q)
      WAIT_A:  if (rx_done_tick) bus_a_d = rx_data;
      WAIT_B:  if (rx_done_tick) bus_b_d = rx_data;
      WAIT_OP: if (rx_done_tick) op_d = rx_data[OP_WIDTH-1:0];
      COMPUTE: tx_data_d = alu_result;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_a_q    <= '0;
      bus_b_q    <= '0;
      op_q       <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      bus_a_q    <= bus_a_d;
      bus_b_q    <= bus_b_d;
      op_q       <= op_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
    end
  end

  assign bus_a    = bus_a_q;
  assign bus_b    = bus_b_q;
  assign op       = op_q;
  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_alu_uart_interface.sv
// Bench for alu_uart_interface: vector table of operations plus hand sequences
// for dropped bytes, mid-operation reset, stray tx_done and the inter-byte gap.
module tb_alu_uart_interface;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_done_tick = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic [7:0] alu_result;
  logic       tx_done_tick = 1'b0;
  logic [7:0] bus_a, bus_b, tx_data;
  logic [5:0] op;
  logic       tx_start, busy;

  int nvec = 0;
  int nerr = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  alu_uart_interface #(.LENGTH(8), .OP_WIDTH(6), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .rx_done_tick(rx_done_tick), .rx_data(rx_data),
    .alu_result(alu_result), .tx_done_tick(tx_done_tick),
    .bus_a(bus_a), .bus_b(bus_b), .op(op), .tx_start(tx_start),
    .tx_data(tx_data), .busy(busy)
  );

  // Stand-in combinational ALU (MIPS funct codes)
  always_comb begin
    alu_result = 8'h00;
    case (op)
      6'h20: alu_result = bus_a + bus_b;
      6'h22: alu_result = bus_a - bus_b;
      6'h24: alu_result = bus_a & bus_b;
      6'h25: alu_result = bus_a | bus_b;
      6'h26: alu_result = bus_a ^ bus_b;
      default: alu_result = 8'h00;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every tx_start must match the oldest outstanding expected result.
  always @(negedge clk) begin
    if (rst_n && tx_start) begin
      if (exp_q.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL spurious_tx_start: got tx_data %0h with nothing expected at %0t", tx_data, $time);
      end else begin
        chk("tx_data", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done_tick = 1'b1;
    @(posedge clk); #1;
    rx_done_tick = 1'b0;
  endtask

  // Sends an operation and checks everything up to entry into WAIT_TX.
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                       input logic [5:0] eop, input logic [7:0] eres,
                       input bit skip_a, input bit done_in_send);
    if (!skip_a) send_byte(a);
    send_byte(b);
    exp_q.push_back(eres);
    send_byte(opb);
    @(negedge clk);
    chk("busy_compute", {31'h0, busy}, 32'd1);
    chk("tx_start_early", {31'h0, tx_start}, 32'd0);
    chk("op", {26'h0, op}, {26'h0, eop});
    chk("bus_b", {24'h0, bus_b}, {24'h0, b});
    if (!skip_a) chk("bus_a", {24'h0, bus_a}, {24'h0, a});
    @(negedge clk);
    chk("tx_start_latency", {31'h0, tx_start}, 32'd1);
    if (done_in_send) tx_done_tick = 1'b1;
    @(posedge clk); #1;
    tx_done_tick = 1'b0;
    @(negedge clk);
    chk("busy_wait_tx", {31'h0, busy}, 32'd1);
    chk("tx_start_single", {31'h0, tx_start}, 32'd0);
  endtask

  task automatic finish_tx();
    repeat (2) @(posedge clk);
    #1;
    chk("busy_hold", {31'h0, busy}, 32'd1);
    tx_done_tick = 1'b1;
    @(posedge clk); #1;
    tx_done_tick = 1'b0;
    chk("busy_release", {31'h0, busy}, 32'd0);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] opb;
    logic [5:0] eop;
    logic [7:0] eres;
  } vec_t;

  vec_t vt[5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, expected finish before %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{8'h05, 8'h03, 8'h20, 6'h20, 8'h08};
    vt[1] = '{8'h03, 8'h05, 8'h22, 6'h22, 8'hFE};
    vt[2] = '{8'hF0, 8'h3C, 8'hE4, 6'h24, 8'h30};
    vt[3] = '{8'hAA, 8'h0F, 8'h25, 6'h25, 8'hAF};
    vt[4] = '{8'hAA, 8'h0F, 8'h26, 6'h26, 8'hA5};

    #2;
    chk("rst_bus_a", {24'h0, bus_a}, 32'h0);
    chk("rst_op", {26'h0, op}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_tx_start", {31'h0, tx_start}, 32'h0);
    #21 rst_n = 1'b1;
    @(posedge clk); #1;

    // Stray tx_done in WAIT_A
    tx_done_tick = 1'b1;
    @(posedge clk); #1;
    tx_done_tick = 1'b0;
    chk("idle_tx_done_busy", {31'h0, busy}, 32'd0);

    foreach (vt[i]) begin
      issue(vt[i].a, vt[i].b, vt[i].opb, vt[i].eop, vt[i].eres, 1'b0, (i == 1));
      finish_tx();
    end

    // Bytes during WAIT_TX are dropped, including one coincident with tx_done
    issue(8'h05, 8'h03, 8'h20, 6'h20, 8'h08, 1'b0, 1'b0);
    rx_data = 8'h77;
    rx_done_tick = 1'b1;
    @(posedge clk); #1;
    rx_done_tick = 1'b0;
    chk("drop_bus_a", {24'h0, bus_a}, 32'h05);
    chk("drop_busy", {31'h0, busy}, 32'd1);
    rx_done_tick = 1'b1;
    tx_done_tick = 1'b1;
    @(posedge clk); #1;
    rx_done_tick = 1'b0;
    tx_done_tick = 1'b0;
    chk("coincide_busy", {31'h0, busy}, 32'd0);
    chk("coincide_bus_a", {24'h0, bus_a}, 32'h05);
    chk("coincide_bus_b", {24'h0, bus_b}, 32'h03);
    issue(8'h01, 8'h01, 8'h20, 6'h20, 8'h02, 1'b0, 1'b0);
    finish_tx();

    // Reset in WAIT_OP clears everything immediately
    send_byte(8'h05);
    send_byte(8'h03);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_bus_a", {24'h0, bus_a}, 32'h0);
    chk("mid_rst_bus_b", {24'h0, bus_b}, 32'h0);
    chk("mid_rst_op", {26'h0, op}, 32'h0);
    chk("mid_rst_tx_data", {24'h0, tx_data}, 32'h0);
    chk("mid_rst_busy", {31'h0, busy}, 32'h0);
    chk("mid_rst_tx_start", {31'h0, tx_start}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue(8'h02, 8'h01, 8'h22, 6'h22, 8'h01, 1'b0, 1'b0);
    finish_tx();

    // Long gap after operand A
    send_byte(8'h09);
    repeat (16) begin
      @(posedge clk); #1;
    end
`ifdef INTERFACE_TIMEOUT_EN
    chk("timeout_busy", {31'h0, busy}, 32'd0);
    issue(8'h04, 8'h04, 8'h20, 6'h20, 8'h08, 1'b0, 1'b0);
`else
    issue(8'h00, 8'h04, 8'h20, 6'h20, 8'h0D, 1'b1, 1'b0);
    chk("gap_bus_a", {24'h0, bus_a}, 32'h09);
`endif
    finish_tx();

    repeat (3) @(posedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/alu_uart_interface.md
Name: alu_uart_interface

Overview:
- Sequencing stage between the UART receiver/transmitter and the combinational ALU (8-bit operands, 6-bit funct-style op).
- Collects three received bytes in order: operand A, operand B, opcode.
- Drives them onto the ALU inputs, captures the ALU result one cycle later, and hands it to the UART transmitter with a start/done handshake.

Parameters:
- LENGTH, 8: operand/result/UART data width in bits; must match the ALU length.
- OP_WIDTH, 6: opcode width; the opcode is taken from rx_data[OP_WIDTH-1:0].
- TIMEOUT_CYCLES, 1000000: inter-byte timeout in clk cycles; used only when INTERFACE_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rx_done_tick  in  1  one-cycle strobe from the UART receiver: rx_data is valid.
- rx_data  in  LENGTH  received byte.
- alu_result  in  LENGTH  combinational output of the ALU (salida).
- tx_done_tick  in  1  one-cycle strobe from the UART transmitter: frame finished.
- bus_a  out  LENGTH  registered operand A to the ALU.
- bus_b  out  LENGTH  registered operand B to the ALU.
- op  out  OP_WIDTH  registered opcode to the ALU.
- tx_start  out  1  one-cycle strobe requesting transmission of tx_data.
- tx_data  out  LENGTH  registered result byte to the transmitter.
- busy  out  1  high while a result is being computed or sent.

Behaviour:
- Reset: one clock, with async active-low reset on rst_n. Asserting rst_n low at any time forces state to WAIT_A and clears bus_a, bus_b, op, tx_data, tx_start and busy to 0. There is no partial recovery; a reset mid-operation discards any collected bytes.
- FSM states: WAIT_A, WAIT_B, WAIT_OP, COMPUTE, SEND, WAIT_TX.
- WAIT_A: on rx_done_tick, bus_a <= rx_data and go to WAIT_B.
- WAIT_B: on rx_done_tick, bus_b <= rx_data and go to WAIT_OP.
- WAIT_OP: on rx_done_tick, op <= rx_data[OP_WIDTH-1:0] and go to COMPUTE. Upper bits of the byte are ignored.
- COMPUTE: lasts exactly one cycle. tx_data <= alu_result, then go to SEND.
- SEND: lasts exactly one cycle. tx_start = 1, then go to WAIT_TX.
- WAIT_TX: on tx_done_tick, go to WAIT_A.
- Latency: if the op byte strobe arrives in cycle n, then COMPUTE occurs in cycle n+1 and tx_start is high in cycle n+2. tx_start is high for exactly one cycle per operation.
- busy = 1 in COMPUTE, SEND and WAIT_TX; otherwise 0. busy is registered and tracks the state.
- bus_a, bus_b and op hold their values until overwritten by the next received sequence. Result arithmetic, including wrap-around and sign, is the ALU's; this block does not alter it.
- rx_done_tick during COMPUTE, SEND or WAIT_TX: the byte is dropped, with no state or register change.
- tx_done_tick outside WAIT_TX is ignored.
- rx_done_tick and tx_done_tick in the same cycle in WAIT_TX: return to WAIT_A and drop the byte.
- All outputs are driven from registers; none are combinational from inputs.

Optional Feature:
- Macro INTERFACE_TIMEOUT_EN.
- When defined: a counter is cleared on every accepted byte and increments each cycle in WAIT_B and WAIT_OP. When the count reaches TIMEOUT_CYCLES-1 with no rx_done_tick, go to WAIT_A. bus_a, bus_b and op keep their values; busy and tx_start are unaffected. The counter is cleared by reset and on entering WAIT_A.
- When undefined: no counter exists, and WAIT_B/WAIT_OP wait indefinitely.

Test Plan:
- Bytes 0x05, 0x03, 0x20 (ADD) -> op=0x20, tx_start pulses exactly 2 cycles after the op strobe, tx_data=0x08, busy high until tx_done_tick.
- Bytes 0x03, 0x05, 0x22 (SUB) -> tx_data=0xFE. Then bytes 0xF0, 0x3C, 0xE4 -> op=0x24 (upper bits stripped), tx_data=0x30.
- During WAIT_TX inject rx_done_tick with 0x77, including one cycle coincident with tx_done_tick -> byte dropped, bus_a unchanged, state returns to WAIT_A. The next bytes 0x01, 0x01, 0x20 yield tx_data=0x02.
- Send 0x05, 0x03, then pulse rst_n low mid-WAIT_OP -> all outputs 0 immediately. Then 0x02, 0x01, 0x22 -> tx_data=0x01 (first post-reset byte treated as A).
- tx_done_tick pulsed in WAIT_A and SEND -> no state change, no extra tx_start.
- With INTERFACE_TIMEOUT_EN, TIMEOUT_CYCLES=16: byte 0x09, then idle 16 cycles -> back in WAIT_A. Next bytes 0x04, 0x04, 0x20 -> tx_data=0x08. Without the macro, the same idle gap followed by 0x04, 0x20 -> A=0x09, B=0x04, op=0x20, tx_data=0x0D.
